// File: rtl/vc_arbiter.sv
// Weighted VC0/VC1 drain into one destination FIFO; pop-to-push latency 1 cycle, grants stall on dest full/almost_full.
// Optional per-VC grant counters are built when VC_ARB_STATS_EN is defined.
module vc_arbiter #(
  parameter int data_width = 6,
  parameter int VC0_WEIGHT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arb_enable,
  input  logic                  empty_VC0,
  input  logic                  empty_VC1,
  input  logic                  error_VC0,
  input  logic                  error_VC1,
  input  logic [data_width-1:0] data_VC0,
  input  logic [data_width-1:0] data_VC1,
  input  logic                  full_dest,
  input  logic                  almost_full_dest,
  output logic                  rd_enable_VC0,
  output logic                  rd_enable_VC1,
  output logic                  push_dest,
  output logic [data_width-1:0] data_out,
  output logic                  arb_error,
  output logic [15:0]           grant_cnt_VC0,
  output logic [15:0]           grant_cnt_VC1
);

  typedef enum logic [1:0] {IDLE, G_VC0, G_VC1, ERR} state_t;

  localparam logic [3:0] WEIGHT = 4'(VC0_WEIGHT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_burst_cnt;
  logic [3:0] w_burst_nxt;
  logic       r_sel_q;
  logic       r_valid_q;
  logic       r_run;
  logic       w_stall;
  logic       w_allow;
  logic       w_gnt0;
  logic       w_gnt1;

  // Almost-full only blocks when a push is already in flight for the last slot.
  assign w_stall = full_dest | (almost_full_dest & r_valid_q);
  // r_run keeps grants off until the first edge after reset release.
  assign w_allow = reset & r_run & arb_enable & ~w_stall & (r_state != ERR);

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_burst_nxt = r_burst_cnt;
    w_state_nxt = IDLE;
    if (w_allow) begin
      if (!empty_VC0 && !empty_VC1) begin
        if (r_burst_cnt < WEIGHT) w_gnt0 = 1'b1;
        else                      w_gnt1 = 1'b1;
      end else if (!empty_VC0) begin
        w_gnt0 = 1'b1;
      end else if (!empty_VC1) begin
        w_gnt1 = 1'b1;
      end
    end
    if (w_gnt0 && (r_burst_cnt < WEIGHT)) w_burst_nxt = r_burst_cnt + 4'd1;
    else if (w_gnt1)                      w_burst_nxt = 4'd0;
    if ((r_state == ERR) || error_VC0 || error_VC1) w_state_nxt = ERR;
    else if (w_gnt0)                                w_state_nxt = G_VC0;
    else if (w_gnt1)                                w_state_nxt = G_VC1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_burst_cnt <= 4'd0;
      r_sel_q     <= 1'b0;
      r_valid_q   <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_sel_q     <= w_gnt1;
      r_valid_q   <= w_gnt0 | w_gnt1;
      r_run       <= 1'b1;
    end
  end

  assign rd_enable_VC0 = w_gnt0;
  assign rd_enable_VC1 = w_gnt1;
  assign push_dest     = r_valid_q;
  assign data_out      = r_valid_q ? (r_sel_q ? data_VC1 : data_VC0) : '0;
  assign arb_error     = (r_state == ERR);

`ifdef VC_ARB_STATS_EN
  logic [15:0] r_gcnt0;
  logic [15:0] r_gcnt1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gcnt0 <= 16'd0;
      r_gcnt1 <= 16'd0;
    end else begin
      if (w_gnt0 && (r_gcnt0 != 16'hFFFF)) r_gcnt0 <= r_gcnt0 + 16'd1;
      if (w_gnt1 && (r_gcnt1 != 16'hFFFF)) r_gcnt1 <= r_gcnt1 + 16'd1;
    end
  end

  assign grant_cnt_VC0 = r_gcnt0;
  assign grant_cnt_VC1 = r_gcnt1;
`else
  assign grant_cnt_VC0 = 16'd0;
  assign grant_cnt_VC1 = 16'd0;
`endif

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter with behavioural source FIFOs and a 16-entry destination FIFO.
module tb_vc_arbiter;
  localparam int DW        = 6;
  localparam int DEST_SIZE = 16;

  logic          clk = 1'b0;
  logic          reset, arb_enable;
  logic          empty_VC0, empty_VC1, error_VC0, error_VC1;
  logic [DW-1:0] data_VC0, data_VC1, data_out;
  logic          full_dest, almost_full_dest;
  logic          rd_enable_VC0, rd_enable_VC1, push_dest, arb_error;
  logic [15:0]   grant_cnt_VC0, grant_cnt_VC1;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            dest_cnt;
  bit            dest_sink, dest_ovf, src_udf;

  always #5 clk = ~clk;

  vc_arbiter #(.data_width(DW), .VC0_WEIGHT(3)) dut (
    .clk(clk), .reset(reset), .arb_enable(arb_enable),
    .empty_VC0(empty_VC0), .empty_VC1(empty_VC1),
    .error_VC0(error_VC0), .error_VC1(error_VC1),
    .data_VC0(data_VC0), .data_VC1(data_VC1),
    .full_dest(full_dest), .almost_full_dest(almost_full_dest),
    .rd_enable_VC0(rd_enable_VC0), .rd_enable_VC1(rd_enable_VC1),
    .push_dest(push_dest), .data_out(data_out), .arb_error(arb_error),
    .grant_cnt_VC0(grant_cnt_VC0), .grant_cnt_VC1(grant_cnt_VC1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic upd_flags();
    empty_VC0        = (q0.size() == 0);
    empty_VC1        = (q1.size() == 0);
    full_dest        = !dest_sink && (dest_cnt >= DEST_SIZE);
    almost_full_dest = !dest_sink && (dest_cnt == DEST_SIZE - 1);
  endtask

  task automatic settle();
    upd_flags();
    #1;
  endtask

  // One clock: apply this cycle's pops/push to the FIFO models, then let outputs settle.
  task automatic tick();
    logic p0, p1, ps;
    p0 = rd_enable_VC0;
    p1 = rd_enable_VC1;
    ps = push_dest;
    @(posedge clk);
    #1;
    if (p0) begin
      if (q0.size() == 0) src_udf = 1'b1;
      else                data_VC0 = q0.pop_front();
    end
    if (p1) begin
      if (q1.size() == 0) src_udf = 1'b1;
      else                data_VC1 = q1.pop_front();
    end
    if (ps && !dest_sink) begin
      if (dest_cnt >= DEST_SIZE) dest_ovf = 1'b1;
      else                       dest_cnt++;
    end
    upd_flags();
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    arb_enable = 1'b0;
    error_VC0  = 1'b0;
    error_VC1  = 1'b0;
    q0.delete();
    q1.delete();
    dest_cnt   = 0;
    dest_sink  = 1'b1;
    dest_ovf   = 1'b0;
    src_udf    = 1'b0;
    data_VC0   = '0;
    data_VC1   = '0;
    upd_flags();
    @(posedge clk);
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic load(input int vc, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (vc == 0) q0.push_back(DW'(base + i));
      else         q1.push_back(DW'(base + i));
    end
  endtask

  initial begin
    int t1_rd[7]   = '{1, 1, 1, 1, 1, 0, 0};
    int t1_push[7] = '{0, 1, 1, 1, 1, 1, 0};
    int t1_dat[7]  = '{0, 1, 2, 3, 4, 5, 0};
    int t2_sel[16] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    int t3_rd[5]   = '{1, 1, 0, 0, 0};
    int t3_push[5] = '{0, 1, 1, 0, 0};
    int i0, i1, prev_dat;

    // Reset state with both sources claiming data
    reset = 1'b0; arb_enable = 1'b1; error_VC0 = 1'b0; error_VC1 = 1'b0;
    empty_VC0 = 1'b0; empty_VC1 = 1'b0; full_dest = 1'b0; almost_full_dest = 1'b0;
    data_VC0 = 6'h15; data_VC1 = 6'h2A;
    #3;
    check("rst_rd0", rd_enable_VC0, 0);
    check("rst_rd1", rd_enable_VC1, 0);
    check("rst_push", push_dest, 0);
    check("rst_data", data_out, 0);
    check("rst_err", arb_error, 0);
    check("rst_cnt0", grant_cnt_VC0, 0);
    check("rst_cnt1", grant_cnt_VC1, 0);

    // VC0 only, five entries
    do_reset();
    arb_enable = 1'b1;
    load(0, 1, 5);
    settle();
    for (int k = 0; k < 7; k++) begin
      check($sformatf("t1_rd0[%0d]", k), rd_enable_VC0, t1_rd[k]);
      check($sformatf("t1_rd1[%0d]", k), rd_enable_VC1, 0);
      check($sformatf("t1_push[%0d]", k), push_dest, t1_push[k]);
      check($sformatf("t1_dat[%0d]", k), data_out, t1_dat[k]);
      tick();
    end

    // Both VCs with 8 entries, weight 3
    do_reset();
    arb_enable = 1'b1;
    load(0, 6'h10, 8);
    load(1, 6'h20, 8);
    settle();
    i0 = 0; i1 = 0; prev_dat = 0;
    for (int k = 0; k < 17; k++) begin
      check($sformatf("t2_rd0[%0d]", k), rd_enable_VC0, (k < 16) && (t2_sel[k] == 0));
      check($sformatf("t2_rd1[%0d]", k), rd_enable_VC1, (k < 16) && (t2_sel[k] == 1));
      check($sformatf("t2_push[%0d]", k), push_dest, k > 0);
      if (k > 0) check($sformatf("t2_dat[%0d]", k), data_out, prev_dat);
      if (k < 16) begin
        if (t2_sel[k] == 0) begin prev_dat = 6'h10 + i0; i0++; end
        else                begin prev_dat = 6'h20 + i1; i1++; end
      end
      tick();
    end
    check("t2_udf", src_udf, 0);

    // Statistics: 10 VC0 and 4 VC1 grants
    do_reset();
    arb_enable = 1'b1;
    load(0, 1, 10);
    load(1, 6'h21, 4);
    settle();
    for (int k = 0; k < 16; k++) tick();
`ifdef VC_ARB_STATS_EN
    check("st_cnt0", grant_cnt_VC0, 10);
    check("st_cnt1", grant_cnt_VC1, 4);
`else
    check("st_cnt0", grant_cnt_VC0, 0);
    check("st_cnt1", grant_cnt_VC1, 0);
`endif
    check("st_q0_drained", q0.size(), 0);
    check("st_q1_drained", q1.size(), 0);

    // Destination pre-filled to 14 of 16
    do_reset();
    dest_sink = 1'b0;
    dest_cnt = 14;
    arb_enable = 1'b1;
    load(0, 6'h08, 8);
    settle();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3_rd0[%0d]", k), rd_enable_VC0, t3_rd[k]);
      check($sformatf("t3_push[%0d]", k), push_dest, t3_push[k]);
      tick();
    end
    check("t3_dest_cnt", dest_cnt, 16);
    check("t3_full", full_dest, 1);
    check("t3_ovf", dest_ovf, 0);
    // One slot frees up with nothing in flight: exactly one grant
    dest_cnt = 15;
    settle();
    check("t3_af_rd0", rd_enable_VC0, 1);
    tick();
    check("t3_af_rd0_after", rd_enable_VC0, 0);
    check("t3_af_push", push_dest, 1);
    tick();
    check("t3_af_cnt", dest_cnt, 16);
    check("t3_af_ovf", dest_ovf, 0);
    check("t3_af_rd0_full", rd_enable_VC0, 0);

    // error_VC1 pulse during a VC0 stream
    do_reset();
    arb_enable = 1'b1;
    load(0, 6'h30, 8);
    settle();
    check("t4_rd0_c0", rd_enable_VC0, 1);
    tick();
    check("t4_rd0_c1", rd_enable_VC0, 1);
    check("t4_dat_c1", data_out, 6'h30);
    error_VC1 = 1'b1;
    #1;
    tick();
    error_VC1 = 1'b0;
    settle();
    check("t4_rd0_c2", rd_enable_VC0, 0);
    check("t4_push_c2", push_dest, 1);
    check("t4_dat_c2", data_out, 6'h31);
    check("t4_err_c2", arb_error, 1);
    for (int k = 3; k < 6; k++) begin
      tick();
      check($sformatf("t4_rd0_c%0d", k), rd_enable_VC0, 0);
      check($sformatf("t4_push_c%0d", k), push_dest, 0);
      check($sformatf("t4_err_c%0d", k), arb_error, 1);
    end
    do_reset();
    check("t4_err_cleared", arb_error, 0);

    // Asynchronous reset mid-burst
    arb_enable = 1'b1;
    load(0, 6'h40, 8);
    load(1, 6'h50, 8);
    settle();
    tick();
    tick();
    check("t5_pre_rd0", rd_enable_VC0, 1);
    reset = 1'b0;
    #1;
    check("t5_rd0", rd_enable_VC0, 0);
    check("t5_rd1", rd_enable_VC1, 0);
    check("t5_push", push_dest, 0);
    check("t5_dat", data_out, 0);
    check("t5_err", arb_error, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rel_rd0", rd_enable_VC0, 0);
    check("t5_rel_push", push_dest, 0);
    tick();
    check("t5_a_rd0", rd_enable_VC0, 1);
    check("t5_a_push", push_dest, 0);
    tick();
    check("t5_b_rd0", rd_enable_VC0, 1);
    check("t5_b_dat", data_out, 6'h42);
    tick();
    check("t5_c_rd0", rd_enable_VC0, 1);
    tick();
    check("t5_d_rd1", rd_enable_VC1, 1);
    check("t5_d_rd0", rd_enable_VC0, 0);
    check("t5_d_dat", data_out, 6'h44);
    tick();
    check("t5_e_dat", data_out, 6'h50);

    // arb_enable dropped mid-stream: in-flight push completes, burst count holds
    do_reset();
    arb_enable = 1'b1;
    load(0, 6'h01, 8);
    load(1, 6'h21, 8);
    settle();
    tick();
    tick();
    arb_enable = 1'b0;
    #1;
    check("t6_off_rd0", rd_enable_VC0, 0);
    check("t6_off_push", push_dest, 1);
    check("t6_off_dat", data_out, 6'h02);
    tick();
    check("t6_idle_push", push_dest, 0);
    arb_enable = 1'b1;
    #1;
    check("t6_on_rd0", rd_enable_VC0, 1);
    tick();
    check("t6_on_rd1", rd_enable_VC1, 1);
    check("t6_on_dat", data_out, 6'h03);
    tick();
    check("t6_vc1_dat", data_out, 6'h21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
